rec_pingpong_ctrl: RTL and testbench
====================================

Name: rec_pingpong_ctrl

Overview:
Recording scheduler for the two 512-byte ping-pong write buffers that feed the SD sector writer. It samples note_data once per CLOCK_IO tick while recording, picks which buffer is filled, and pads a partial sector with zeros when recording stops. It hands each full buffer to the CLOCK_10-domain SD writer over a per-buffer 4-phase req/ack handshake, and flags overflow when both buffers are still pending.

Parameters:
DEPTH, 512, bytes per buffer (one SD sector)
ADDR_W, 9, buffer address width, log2(DEPTH)
DATA_W, 8, note sample width
MAX_SECTORS, 16'd4096, sector limit; recording stops at this count
SYNC_STAGES, 2, synchronizer depth on drain_ack

Ports:
CLOCK_IO  in  1  sample/state clock
resetn  in  1  asynchronous, active-low reset
mode_write  in  1  record enable (level)
note_data  in  DATA_W  current note code (0 = rest, 1..12)
drain_ack  in  2  per-buffer ack from SD writer, asynchronous (CLOCK_10 domain)
buf_we  out  2  one-hot write enable, buffer 0/1
buf_addr  out  ADDR_W  write address into the selected buffer
buf_wdata  out  DATA_W  write data
drain_req  out  2  per-buffer drain request (4-phase)
sector_count  out  16  sectors handed off since reset
overflow  out  1  sticky; a sample was dropped
rec_done  out  1  sticky; MAX_SECTORS reached
busy  out  1  state != IDLE

Behaviour:
- Reset (async, resetn=0): state=IDLE, active=0, addr=0, pending=2'b00. All outputs are 0.
- drain_ack passes through a SYNC_STAGES flop chain on CLOCK_IO, giving ack_s. All logic uses ack_s only.
- Handshake per buffer i, at handoff:
  - drain_req[i] <= 1 and pending[i] <= 1.
  - drain_req[i] drops on the first cycle ack_s[i] = 1.
  - pending[i] clears on the first cycle ack_s[i] = 0 after that.
  - The writer must hold ack until req falls.
- States:
  - IDLE: buf_we = 0. mode_write=1, rec_done=0 and pending[active]=0 -> FILL. addr holds at 0.
  - FILL: every cycle, buf_we[active]=1, buf_wdata=note_data, buf_addr=addr, addr++.
    - Write at addr=DEPTH-1: hand off active, sector_count++, addr wraps to 0, active toggles.
    - That same cycle: if pending[~active]=1 or sector_count+1=MAX_SECTORS, go to WAIT_FREE or DONE respectively.
    - mode_write=0 with addr=0 -> IDLE, no handoff.
    - mode_write=0 with addr>0 -> PAD.
  - PAD: writes 8'd0 at addr++ until the DEPTH-1 write. Then hand off as above, toggle active, -> IDLE. mode_write is ignored in PAD.
  - WAIT_FREE: buf_we = 0. Each cycle with mode_write=1 is a dropped sample and sets overflow.
    - pending[active] clears -> FILL at addr 0 if mode_write=1, else IDLE.
  - DONE: rec_done=1 (sticky), buf_we = 0. Outstanding handshakes still complete. Only reset exits DONE.
- Simultaneous events:
  - mode_write falling on the DEPTH-1 write: the handoff wins and the next state is IDLE (no PAD).
  - Handoff and ack edge in the same cycle on different buffers are independent.
- Latency:
  - Sample to buffer write: same cycle (combinational addr/data, registered state).
  - Handoff to drain_req: 1 cycle.
- sector_count saturates at MAX_SECTORS. Width is 16 bits; no wrap.
- Reset mid-operation drops drain_req immediately. The SD writer must abort on resetn as well.
- busy=1 in FILL, PAD, WAIT_FREE and DONE.

Decomposition:
- Shared package rec_pkg: state enum (IDLE, FILL, PAD, WAIT_FREE, DONE), REST_CODE=8'd0, DEPTH/ADDR_W defaults.
- Sub-module sync_bit_n: generic SYNC_STAGES flop synchronizer, instantiated per drain_ack bit. It is reusable by the CLOCK_10-side writer for drain_req.

Test Plan:
- Reset then mode_write=1 for 512 cycles with note_data=8'd5 -> buffer 0 addr 0..511 written with 5. drain_req=2'b01 on cycle 513; sector_count=1; active=1.
- Ack 4 cycles after req, released after req falls; record 1024 cycles -> both buffers handed off alternately, sector_count=2, overflow=0.
- Never ack; record 1100 cycles -> buffer 0 then buffer 1 handed off at cycles 512/1024, WAIT_FREE from cycle 1025, overflow=1. After ack/release of buffer 0 -> FILL resumes at addr 0 of buffer 0.
- mode_write=1 for 100 cycles then 0 -> addr 100..511 written with 0, drain_req[0] rises after the 511 write, state returns to IDLE.
- MAX_SECTORS=2, continuous record with prompt acks -> after the second handoff, DONE, rec_done=1, buf_we stays 0 while mode_write=1.
- Assert resetn=0 during PAD at addr 300 -> drain_req=0, sector_count=0, buf_we=0 immediately (asynchronous, before the next CLOCK_IO edge).

Source files
------------

// File: rtl/rec_pkg.sv
// Shared definitions for the recording ping-pong buffer scheduler:
// controller states, default buffer geometry and the pad value.
package rec_pkg;

  localparam int REC_DEPTH  = 512;
  localparam int REC_ADDR_W = 9;
  localparam int REC_DATA_W = 8;

  localparam logic [REC_DATA_W-1:0] REST_CODE = 8'd0;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    PAD,
    WAIT_FREE,
    DONE
  } rec_state_t;

endpackage

// File: rtl/rec_pingpong_ctrl_if.sv
// Buffer write port plus per-buffer drain handshake between the recording
// scheduler (master) and the buffer/SD-writer side (slave).
interface rec_pingpong_ctrl_if import rec_pkg::*; #(
  parameter int ADDR_W = REC_ADDR_W,
  parameter int DATA_W = REC_DATA_W
) ();

  logic [1:0]        buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic [1:0]        drain_req;
  logic [1:0]        drain_ack;

  modport master (
    output buf_we, buf_addr, buf_wdata, drain_req,
    input  drain_ack
  );

  modport slave (
    input  buf_we, buf_addr, buf_wdata, drain_req,
    output drain_ack
  );

endinterface

// File: rtl/sync_bit_n.sv
// Generic single-bit flop-chain synchronizer (SYNC_STAGES >= 2), usable on
// either side of the CLOCK_IO / CLOCK_10 boundary.
module sync_bit_n #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLOCK_IO,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge CLOCK_IO or negedge resetn) begin
    if (!resetn) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/rec_pingpong_ctrl.sv
// Recording scheduler: fills two ping-pong sector buffers from note_data,
// zero-pads partial sectors and hands full buffers to the SD writer.
module rec_pingpong_ctrl import rec_pkg::*; #(
  parameter int          DEPTH       = REC_DEPTH,
  parameter int          ADDR_W      = REC_ADDR_W,
  parameter int          DATA_W      = REC_DATA_W,
  parameter logic [15:0] MAX_SECTORS = 16'd4096,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                CLOCK_IO,
  input  logic                resetn,
  input  logic                mode_write,
  input  logic [DATA_W-1:0]   note_data,
  rec_pingpong_ctrl_if.master bus,
  output logic [15:0]         sector_count,
  output logic                overflow,
  output logic                rec_done,
  output logic                busy
);

  rec_state_t        state_reg, state_next;
  logic              active_reg, active_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [15:0]       sector_count_reg;
  logic              overflow_reg;
  logic              rec_done_reg;
  logic [1:0]        pending_reg;
  logic [1:0]        drain_req_reg;
  logic [1:0]        ack_s;

  logic              handoff;
  logic [1:0]        buf_we;
  logic [DATA_W-1:0] wdata;
  logic              last_addr;
  logic              at_limit;

  assign last_addr = (addr_reg == ADDR_W'(DEPTH - 1));
  // Widened so a MAX_SECTORS of 16'hFFFF cannot wrap the comparison.
  assign at_limit  = ({1'b0, sector_count_reg} + 17'd1) >= {1'b0, MAX_SECTORS};

  always_comb begin
    state_next  = state_reg;
    active_next = active_reg;
    addr_next   = addr_reg;
    buf_we      = 2'b00;
    wdata       = '0;
    handoff     = 1'b0;

    case (state_reg)
      IDLE: begin
        addr_next = '0;
        if (mode_write && !rec_done_reg && !pending_reg[active_reg]) begin
          state_next = FILL;
        end
      end

      FILL: begin
        // The final slot is always written so a stop on it still yields a full sector.
        if (mode_write || last_addr) begin
          buf_we[active_reg] = 1'b1;
          wdata              = mode_write ? note_data : REST_CODE;
          if (last_addr) begin
            handoff     = 1'b1;
            addr_next   = '0;
            active_next = ~active_reg;
            if (at_limit) begin
              state_next = DONE;
            end else if (pending_reg[~active_reg]) begin
              state_next = WAIT_FREE;
            end else if (!mode_write) begin
              state_next = IDLE;
            end
          end else begin
            addr_next = addr_reg + ADDR_W'(1);
          end
        end else if (addr_reg == '0) begin
          state_next = IDLE;
        end else begin
          state_next = PAD;
        end
      end

      PAD: begin
        buf_we[active_reg] = 1'b1;
        wdata              = REST_CODE;
        if (last_addr) begin
          handoff     = 1'b1;
          addr_next   = '0;
          active_next = ~active_reg;
          state_next  = at_limit ? DONE : IDLE;
        end else begin
          addr_next = addr_reg + ADDR_W'(1);
        end
      end

      WAIT_FREE: begin
        if (!pending_reg[active_reg]) begin
          state_next = mode_write ? FILL : IDLE;
        end
      end

      DONE: begin
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_IO or negedge resetn) begin
    if (!resetn) begin
      state_reg        <= IDLE;
      active_reg       <= 1'b0;
      addr_reg         <= '0;
      sector_count_reg <= '0;
      overflow_reg     <= 1'b0;
      rec_done_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      active_reg <= active_next;
      addr_reg   <= addr_next;
      if (handoff && (sector_count_reg != MAX_SECTORS)) begin
        sector_count_reg <= sector_count_reg + 16'd1;
      end
      if ((state_reg == WAIT_FREE) && mode_write) begin
        overflow_reg <= 1'b1;
      end
      if (state_next == DONE) begin
        rec_done_reg <= 1'b1;
      end
    end
  end

  // Per-buffer 4-phase handshake: req falls on ack, buffer frees when ack falls.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      logic req_reg;
      logic pend_reg;

      sync_bit_n #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_ack_sync (
        .CLOCK_IO(CLOCK_IO),
        .resetn  (resetn),
        .d       (bus.drain_ack[gi]),
        .q       (ack_s[gi])
      );

      always_ff @(posedge CLOCK_IO or negedge resetn) begin
        if (!resetn) begin
          req_reg  <= 1'b0;
          pend_reg <= 1'b0;
        end else if (handoff && (active_reg == 1'(gi))) begin
          req_reg  <= 1'b1;
          pend_reg <= 1'b1;
        end else if (req_reg) begin
          if (ack_s[gi]) begin
            req_reg <= 1'b0;
          end
        end else if (pend_reg && !ack_s[gi]) begin
          pend_reg <= 1'b0;
        end
      end

      assign drain_req_reg[gi] = req_reg;
      assign pending_reg[gi]   = pend_reg;
    end
  endgenerate

  assign bus.buf_we    = buf_we;
  assign bus.buf_addr  = addr_reg;
  assign bus.buf_wdata = wdata;
  assign bus.drain_req = drain_req_reg;
  assign sector_count  = sector_count_reg;
  assign overflow      = overflow_reg;
  assign rec_done      = rec_done_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_rec_pingpong_ctrl.sv
// Directed bench for rec_pingpong_ctrl: a full-size instance plus a
// MAX_SECTORS=2 instance, with a simple SD-writer ack responder.
module tb_rec_pingpong_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       mode_write = 1'b0;
  logic [7:0] note_data = 8'd0;

  logic [15:0] sector_count1, sector_count2;
  logic        overflow1, overflow2, rec_done1, rec_done2, busy1, busy2;

  int errors = 0;
  int checks = 0;

  logic       auto_ack = 1'b0;
  logic [1:0] man_ack  = 2'b00;
  logic [7:0] exp_data = 8'd0;

  int wr_cnt [2];
  int exp_addr [2];
  int wr_bad;

  always #5 clk = ~clk;

  rec_pingpong_ctrl_if bus1 ();
  rec_pingpong_ctrl_if bus2 ();

  rec_pingpong_ctrl dut (
    .CLOCK_IO    (clk),
    .resetn      (resetn),
    .mode_write  (mode_write),
    .note_data   (note_data),
    .bus         (bus1),
    .sector_count(sector_count1),
    .overflow    (overflow1),
    .rec_done    (rec_done1),
    .busy        (busy1)
  );

  rec_pingpong_ctrl #(.MAX_SECTORS(16'd2)) dut_lim (
    .CLOCK_IO    (clk),
    .resetn      (resetn),
    .mode_write  (mode_write),
    .note_data   (note_data),
    .bus         (bus2),
    .sector_count(sector_count2),
    .overflow    (overflow2),
    .rec_done    (rec_done2),
    .busy        (busy2)
  );

  // SD-writer stand-in: ack 4 cycles after req, release once req falls.
  initial begin
    int cnt1 [2];
    int cnt2 [2];
    cnt1 = '{0, 0};
    cnt2 = '{0, 0};
    bus1.drain_ack = 2'b00;
    bus2.drain_ack = 2'b00;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (auto_ack) begin
          if (bus1.drain_req[i] && !bus1.drain_ack[i]) begin
            cnt1[i]++;
            if (cnt1[i] >= 4) bus1.drain_ack[i] = 1'b1;
          end else if (!bus1.drain_req[i] && bus1.drain_ack[i]) begin
            bus1.drain_ack[i] = 1'b0;
            cnt1[i] = 0;
          end
        end else begin
          bus1.drain_ack[i] = man_ack[i];
          cnt1[i] = 0;
        end
        if (bus2.drain_req[i] && !bus2.drain_ack[i]) begin
          cnt2[i]++;
          if (cnt2[i] >= 4) bus2.drain_ack[i] = 1'b1;
        end else if (!bus2.drain_req[i] && bus2.drain_ack[i]) begin
          bus2.drain_ack[i] = 1'b0;
          cnt2[i] = 0;
        end
      end
    end
  end

  // Write monitor for the full-size instance: address sequence, data, one-hot.
  always @(negedge clk) begin
    if (!resetn) begin
      wr_cnt   = '{0, 0};
      exp_addr = '{0, 0};
      wr_bad   = 0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (bus1.buf_we[b]) begin
          if (bus1.buf_addr !== 9'(exp_addr[b]) || bus1.buf_wdata !== exp_data) wr_bad++;
          exp_addr[b] = (exp_addr[b] + 1) % 512;
          wr_cnt[b]++;
        end
      end
      if (bus1.buf_we == 2'b11) wr_bad++;
    end
  end

  task automatic do_reset();
    resetn     = 1'b0;
    mode_write = 1'b0;
    auto_ack   = 1'b0;
    man_ack    = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    @(negedge clk);
    checks++; if (bus1.buf_we !== 2'b00) begin errors++; $display("FAIL reset_buf_we: got %b expected 00", bus1.buf_we); end
    checks++; if (bus1.drain_req !== 2'b00) begin errors++; $display("FAIL reset_drain_req: got %b expected 00", bus1.drain_req); end
    checks++; if (sector_count1 !== 16'd0) begin errors++; $display("FAIL reset_sector_count: got %0d expected 0", sector_count1); end
    checks++; if (busy1 !== 1'b0 || overflow1 !== 1'b0 || rec_done1 !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b overflow=%b rec_done=%b expected 0", busy1, overflow1, rec_done1); end
    checks++; if (bus1.buf_addr !== 9'd0 || bus1.buf_wdata !== 8'd0) begin errors++; $display("FAIL reset_bus: addr=%0d wdata=%0d expected 0", bus1.buf_addr, bus1.buf_wdata); end
    $display("test_reset: done");
  endtask

  task automatic test_first_fill();
    do_reset();
    note_data = 8'd5;
    exp_data  = 8'd5;
    mode_write = 1'b1;
    repeat (512) @(posedge clk);
    @(negedge clk);
    checks++; if (bus1.drain_req !== 2'b00 || sector_count1 !== 16'd0) begin errors++; $display("FAIL fill_pre_handoff: req=%b count=%0d expected 00/0", bus1.drain_req, sector_count1); end
    checks++; if (bus1.buf_we !== 2'b01 || bus1.buf_addr !== 9'd511) begin errors++; $display("FAIL fill_last_write: we=%b addr=%0d expected 01/511", bus1.buf_we, bus1.buf_addr); end
    @(posedge clk);
    #1;
    mode_write = 1'b0;
    @(negedge clk);
    checks++; if (bus1.drain_req !== 2'b01) begin errors++; $display("FAIL fill_handoff_req: got %b expected 01", bus1.drain_req); end
    checks++; if (sector_count1 !== 16'd1) begin errors++; $display("FAIL fill_sector_count: got %0d expected 1", sector_count1); end
    checks++; if (wr_cnt[0] !== 512 || wr_cnt[1] !== 0 || wr_bad !== 0) begin errors++; $display("FAIL fill_writes: buf0=%0d buf1=%0d bad=%0d expected 512/0/0", wr_cnt[0], wr_cnt[1], wr_bad); end
    @(negedge clk);
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL fill_back_to_idle: busy=%b expected 0", busy1); end
    $display("test_first_fill: writes buf0=%0d sector_count=%0d", wr_cnt[0], sector_count1);
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    auto_ack   = 1'b1;
    note_data  = 8'd3;
    exp_data   = 8'd3;
    mode_write = 1'b1;
    repeat (1025) @(posedge clk);
    #1;
    mode_write = 1'b0;
    @(negedge clk);
    checks++; if (sector_count1 !== 16'd2) begin errors++; $display("FAIL b2b_sector_count: got %0d expected 2", sector_count1); end
    checks++; if (wr_cnt[0] !== 512 || wr_cnt[1] !== 512 || wr_bad !== 0) begin errors++; $display("FAIL b2b_writes: buf0=%0d buf1=%0d bad=%0d expected 512/512/0", wr_cnt[0], wr_cnt[1], wr_bad); end
    checks++; if (overflow1 !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", overflow1); end
    checks++; if (bus1.drain_req !== 2'b10) begin errors++; $display("FAIL b2b_req: got %b expected 10", bus1.drain_req); end
    n = 0;
    while (bus1.drain_req !== 2'b00 && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (bus1.drain_req !== 2'b00) begin errors++; $display("FAIL b2b_req_release: got %b expected 00 within 40 cycles", bus1.drain_req); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%b expected 0", busy1); end
    $display("test_back_to_back: sector_count=%0d", sector_count1);
  endtask

  task automatic test_pad();
    do_reset();
    note_data  = 8'd9;
    exp_data   = 8'd9;
    mode_write = 1'b1;
    repeat (101) @(posedge clk);
    #1;
    mode_write = 1'b0;
    exp_data   = 8'd0;
    repeat (412) @(posedge clk);
    @(negedge clk);
    checks++; if (bus1.drain_req !== 2'b00 || busy1 !== 1'b1) begin errors++; $display("FAIL pad_before_last: req=%b busy=%b expected 00/1", bus1.drain_req, busy1); end
    checks++; if (bus1.buf_addr !== 9'd511 || bus1.buf_wdata !== 8'd0) begin errors++; $display("FAIL pad_last_slot: addr=%0d wdata=%0d expected 511/0", bus1.buf_addr, bus1.buf_wdata); end
    @(negedge clk);
    checks++; if (bus1.drain_req !== 2'b01 || sector_count1 !== 16'd1) begin errors++; $display("FAIL pad_handoff: req=%b count=%0d expected 01/1", bus1.drain_req, sector_count1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL pad_idle: busy=%b expected 0", busy1); end
    checks++; if (wr_cnt[0] !== 512 || wr_cnt[1] !== 0 || wr_bad !== 0) begin errors++; $display("FAIL pad_writes: buf0=%0d buf1=%0d bad=%0d expected 512/0/0", wr_cnt[0], wr_cnt[1], wr_bad); end
    $display("test_pad: writes buf0=%0d", wr_cnt[0]);
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    note_data  = 8'd7;
    exp_data   = 8'd7;
    mode_write = 1'b1;
    repeat (1025) @(posedge clk);
    @(negedge clk);
    checks++; if (overflow1 !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("FAIL ovf_enter_wait: overflow=%b busy=%b expected 0/1", overflow1, busy1); end
    checks++; if (bus1.buf_we !== 2'b00) begin errors++; $display("FAIL ovf_no_write: we=%b expected 00", bus1.buf_we); end
    repeat (75) @(posedge clk);
    @(negedge clk);
    checks++; if (overflow1 !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow1); end
    checks++; if (bus1.drain_req !== 2'b11 || sector_count1 !== 16'd2) begin errors++; $display("FAIL ovf_both_pending: req=%b count=%0d expected 11/2", bus1.drain_req, sector_count1); end
    checks++; if (wr_cnt[0] !== 512 || wr_cnt[1] !== 512 || wr_bad !== 0) begin errors++; $display("FAIL ovf_writes: buf0=%0d buf1=%0d bad=%0d expected 512/512/0", wr_cnt[0], wr_cnt[1], wr_bad); end
    @(posedge clk);
    #1;
    man_ack = 2'b01;
    n = 0;
    while (bus1.drain_req[0] !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (bus1.drain_req !== 2'b10) begin errors++; $display("FAIL ovf_req0_drop: req=%b expected 10 within 20 cycles", bus1.drain_req); end
    man_ack = 2'b00;
    n = 0;
    while (bus1.buf_we !== 2'b01 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (bus1.buf_we !== 2'b01 || bus1.buf_addr !== 9'd0) begin errors++; $display("FAIL ovf_resume: we=%b addr=%0d expected 01/0 within 20 cycles", bus1.buf_we, bus1.buf_addr); end
    checks++; if (overflow1 !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow1); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (wr_cnt[1] !== 512 || wr_bad !== 0) begin errors++; $display("FAIL ovf_resume_writes: buf1=%0d bad=%0d expected 512/0", wr_cnt[1], wr_bad); end
    mode_write = 1'b0;
    $display("test_overflow: overflow=%b buf0 writes=%0d", overflow1, wr_cnt[0]);
  endtask

  task automatic test_async_reset();
    do_reset();
    note_data  = 8'd4;
    exp_data   = 8'd4;
    mode_write = 1'b1;
    repeat (613) @(posedge clk);
    #1;
    mode_write = 1'b0;
    exp_data   = 8'd0;
    repeat (201) @(posedge clk);
    #2;
    checks++; if (bus1.buf_we !== 2'b10 || bus1.buf_addr !== 9'd300) begin errors++; $display("FAIL areset_pad_pos: we=%b addr=%0d expected 10/300", bus1.buf_we, bus1.buf_addr); end
    checks++; if (bus1.drain_req !== 2'b01 || sector_count1 !== 16'd1) begin errors++; $display("FAIL areset_pre: req=%b count=%0d expected 01/1", bus1.drain_req, sector_count1); end
    resetn = 1'b0;
    #1;
    checks++; if (bus1.drain_req !== 2'b00 || sector_count1 !== 16'd0) begin errors++; $display("FAIL areset_now: req=%b count=%0d expected 00/0", bus1.drain_req, sector_count1); end
    checks++; if (bus1.buf_we !== 2'b00 || busy1 !== 1'b0) begin errors++; $display("FAIL areset_idle: we=%b busy=%b expected 00/0", bus1.buf_we, busy1); end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    $display("test_async_reset: done");
  endtask

  task automatic test_max_sectors();
    int writes;
    int late_writes;
    int n;
    do_reset();
    note_data   = 8'd11;
    mode_write  = 1'b1;
    writes      = 0;
    late_writes = 0;
    for (int c = 0; c < 1045; c++) begin
      @(negedge clk);
      if (bus2.buf_we !== 2'b00) begin
        writes++;
        if (rec_done2) late_writes++;
      end
    end
    checks++; if (writes !== 1024 || late_writes !== 0) begin errors++; $display("FAIL max_writes: writes=%0d after_done=%0d expected 1024/0", writes, late_writes); end
    checks++; if (rec_done2 !== 1'b1 || busy2 !== 1'b1) begin errors++; $display("FAIL max_done: rec_done=%b busy=%b expected 1/1", rec_done2, busy2); end
    checks++; if (sector_count2 !== 16'd2 || overflow2 !== 1'b0) begin errors++; $display("FAIL max_count: count=%0d overflow=%b expected 2/0", sector_count2, overflow2); end
    checks++; if (rec_done1 !== 1'b0) begin errors++; $display("FAIL max_full_size_not_done: rec_done=%b expected 0", rec_done1); end
    mode_write = 1'b0;
    n = 0;
    while (bus2.drain_req !== 2'b00 && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (bus2.drain_req !== 2'b00) begin errors++; $display("FAIL max_handshake_done: req=%b expected 00 within 40 cycles", bus2.drain_req); end
    mode_write = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (bus2.buf_we !== 2'b00 || busy2 !== 1'b1 || rec_done2 !== 1'b1) begin errors++; $display("FAIL max_stays_done: we=%b busy=%b rec_done=%b expected 00/1/1", bus2.buf_we, busy2, rec_done2); end
    mode_write = 1'b0;
    $display("test_max_sectors: writes=%0d sector_count=%0d", writes, sector_count2);
  endtask

  initial begin
    test_reset();
    test_first_fill();
    test_back_to_back();
    test_pad();
    test_overflow();
    test_async_reset();
    test_max_sectors();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
